// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - shared widths and sideband layout for the sonar baseband path
//
// Purpose:
//   Common constants for the I/Q baseband blocks.
//   - Default sample width.
//   - Channel index width.
//   - Layout of the {channel, iq} sideband carried on tuser.
//   - The stream index type.
//   - A helper that sizes per-stream window counters.
// Ports: none (package).

package sonar_pkg;

  localparam int DATA_W_DEFAULT = 24;
  localparam int CH_W_DEFAULT   = 2;

  // tuser = {channel, iq}; iq=0 is I, iq=1 is Q
  localparam int TUSER_W        = CH_W_DEFAULT + 1;
  localparam int TUSER_IQ_BIT   = 0;
  localparam int TUSER_CH_LSB   = 1;
  localparam int TUSER_CH_MSB   = CH_W_DEFAULT;
  localparam int NUM_STREAMS    = 2 ** TUSER_W;

  typedef logic [TUSER_W-1:0] stream_idx_t;

  // A window counter needs LOG2_DECIM bits. With DECIM=1 it carries no
  // information, but it is kept one bit wide so that it stays a legal vector.
  // It then stays at zero, and zero equals DECIM-1, so every beat dumps.
  function automatic int cnt_width(input int log2_decim);
    return (log2_decim > 0) ? log2_decim : 1;
  endfunction

endpackage

// File: rtl/iq_acc_bank.sv
// rtl/iq_acc_bank.sv - per-stream accumulator, window counter and sticky tlast storage
//
// Purpose:
//   Holds one {acc, cnt, lst} entry per stream.
//   The read is combinational at rd_idx.
//   A single write port updates the entry at wr_idx:
//     - wr_clr: the entry returns to zero (end of a window).
//     - otherwise: acc += wr_add, cnt += 1, lst |= wr_flag.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears all entries)
//   rd_idx            stream index to read
//   rd_acc/cnt/lst    stored accumulator, window count and sticky tlast of rd_idx
//   wr_en             apply an update this cycle
//   wr_idx            stream index to update
//   wr_clr            clear the entry instead of accumulating
//   wr_add            sign-extended sample to add
//   wr_flag           tlast of the sample, folded into the sticky flag

module iq_acc_bank #(
  parameter int ACC_W = 28,
  parameter int CNT_W = 4,
  parameter int IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic signed [ACC_W-1:0] rd_acc,
  output logic [CNT_W-1:0]        rd_cnt,
  output logic                    rd_lst,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic                    wr_clr,
  input  logic signed [ACC_W-1:0] wr_add,
  input  logic                    wr_flag
);

  localparam int DEPTH = 2 ** IDX_W;

  logic signed [ACC_W-1:0] acc_mem [DEPTH];
  logic [CNT_W-1:0]        cnt_mem [DEPTH];
  logic                    lst_mem [DEPTH];

  assign rd_acc = acc_mem[rd_idx];
  assign rd_cnt = cnt_mem[rd_idx];
  assign rd_lst = lst_mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        acc_mem[i] <= '0;
        cnt_mem[i] <= '0;
        lst_mem[i] <= 1'b0;
      end
    end else if (wr_en) begin
      if (wr_clr) begin
        acc_mem[wr_idx] <= '0;
        cnt_mem[wr_idx] <= '0;
        lst_mem[wr_idx] <= 1'b0;
      end else begin
        acc_mem[wr_idx] <= acc_mem[wr_idx] + wr_add;
        cnt_mem[wr_idx] <= cnt_mem[wr_idx] + CNT_W'(1);
        lst_mem[wr_idx] <= lst_mem[wr_idx] | wr_flag;
      end
    end
  end

endmodule

// File: rtl/iq_boxcar_decimator.sv
// rtl/iq_boxcar_decimator.sv - per-stream accumulate-and-dump decimator for interleaved I/Q
//
// Purpose:
//   Low-pass filters and decimates 2**(CH_W+1) interleaved baseband streams.
//   A stream is one {channel, iq} pair. Each stream sums DECIM = 2**LOG2_DECIM
//   of its own beats. It then emits the floor mean, which is the sum shifted
//   right arithmetically by LOG2_DECIM. The output sits behind a one-deep
//   register with a ready/valid handshake.
// Ports:
//   s_axis_aclk     sole clock
//   s_axis_aresetn  asynchronous active-low reset
//   s_axis_tdata    signed input sample
//   s_axis_tvalid   input beat valid
//   s_axis_tready   input beat accepted when tvalid & tready (0 during reset)
//   s_axis_tuser    {channel, iq} stream index of the input beat
//   s_axis_tlast    end-of-ping marker
//   m_axis_tdata    signed decimated sample
//   m_axis_tvalid   output beat valid
//   m_axis_tready   downstream ready
//   m_axis_tuser    {channel, iq} of the dumped stream
//   m_axis_tlast    OR of tlast over the window's input beats

module iq_boxcar_decimator
  import sonar_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int CH_W       = CH_W_DEFAULT,
  parameter int LOG2_DECIM = 4
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [CH_W:0]     s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CH_W:0]     m_axis_tuser,
  output logic              m_axis_tlast
);

  // The accumulator grows by LOG2_DECIM bits. That is exactly enough to hold
  // DECIM full-scale samples, so the sum can never wrap.
  localparam int ACC_W = DATA_W + LOG2_DECIM;
  localparam int CNT_W = cnt_width(LOG2_DECIM);
  localparam int IDX_W = CH_W + 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_DECIM) - 1);

  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] rd_acc;
  logic [CNT_W-1:0]        rd_cnt;
  logic                    rd_lst;
  logic                    accept;
  logic                    dump;
  logic [DATA_W-1:0]       dump_data;

  // The gate on the reset input holds tready low for the whole time reset is
  // asserted. Without it, the empty output register would make tready 1.
  assign s_axis_tready = s_axis_aresetn & (~m_axis_tvalid | m_axis_tready);

  assign accept     = s_axis_tvalid & s_axis_tready;
  assign sample_ext = ACC_W'($signed(s_axis_tdata));
  assign dump       = accept & (rd_cnt == LAST_CNT);

  // An arithmetic shift of the full sum floors toward negative infinity.
  // The mean of DECIM in-range samples always fits back into DATA_W bits,
  // so the truncation below keeps only sign-extension bits.
  assign dump_data  = DATA_W'((rd_acc + sample_ext) >>> LOG2_DECIM);

  iq_acc_bank #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk     (s_axis_aclk),
    .rst_n   (s_axis_aresetn),
    .rd_idx  (s_axis_tuser),
    .rd_acc  (rd_acc),
    .rd_cnt  (rd_cnt),
    .rd_lst  (rd_lst),
    .wr_en   (accept),
    .wr_idx  (s_axis_tuser),
    .wr_clr  (dump),
    .wr_add  (sample_ext),
    .wr_flag (s_axis_tlast)
  );

  // Output register. A dump is only accepted when the register is empty or
  // is being drained this cycle, so loading it never overwrites a pending beat.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (dump) begin
      m_axis_tdata  <= dump_data;
      m_axis_tuser  <= s_axis_tuser;
      m_axis_tlast  <= rd_lst | s_axis_tlast;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iq_boxcar_decimator.sv
// tb/tb_iq_boxcar_decimator.sv - self-checking bench for iq_boxcar_decimator

module tb_iq_boxcar_decimator;
  import sonar_pkg::*;

  localparam int DATA_W     = 24;
  localparam int CH_W       = 2;
  localparam int LOG2_DECIM = 2;
  localparam int DECIM      = 4;
  localparam int NS         = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic [CH_W:0]     s_tuser;
  logic              s_tlast;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic [CH_W:0]     m_tuser;
  logic              m_tlast;

  always #5 clk = ~clk;

  iq_boxcar_decimator #(
    .DATA_W     (DATA_W),
    .CH_W       (CH_W),
    .LOG2_DECIM (LOG2_DECIM)
  ) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .s_axis_tuser   (s_tuser),
    .s_axis_tlast   (s_tlast),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tuser   (m_tuser),
    .m_axis_tlast   (m_tlast)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc_cyc;
  bit rnd_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    stream_idx_t       user;
    logic              last;
    int                cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];

  // Reference model: running sum, beat count and sticky last per stream
  longint m_sum [NS];
  int     m_cnt [NS];
  bit     m_lst [NS];

  // Inputs change at posedge+1, so everything is stable at the negedge
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      beat_t b;
      b.data = m_tdata;
      b.user = m_tuser;
      b.last = m_tlast;
      b.cyc  = cyc;
      obs_q.push_back(b);
    end
  end

  function automatic longint floor_div(input longint s, input longint d);
    longint q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_sum[i] = 0;
      m_cnt[i] = 0;
      m_lst[i] = 0;
    end
    exp_q.delete();
  endfunction

  function automatic void model_accept(input int k, input int d, input bit last);
    beat_t  b;
    longint q;
    m_sum[k] = m_sum[k] + d;
    m_cnt[k] = m_cnt[k] + 1;
    m_lst[k] = m_lst[k] | last;
    if (m_cnt[k] == DECIM) begin
      q      = floor_div(m_sum[k], DECIM);
      b.data = q[DATA_W-1:0];
      b.user = k[CH_W:0];
      b.last = m_lst[k];
      b.cyc  = 0;
      exp_q.push_back(b);
      m_sum[k] = 0;
      m_cnt[k] = 0;
      m_lst[k] = 0;
    end
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(0, (1 << DATA_W) - 1)) - (1 << (DATA_W - 1));
  endfunction

  task automatic send_beat(input int k, input int d, input bit last);
    bit done;
    done     = 0;
    s_tvalid = 1'b1;
    s_tuser  = k[CH_W:0];
    s_tdata  = d[DATA_W-1:0];
    s_tlast  = last;
    for (int i = 0; i < 200 && !done; i++) begin
      if (rnd_ready) m_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_tready) begin
        done         = 1;
        last_acc_cyc = cyc;
        model_accept(k, d, last);
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout stream=%0d got=no_accept want=accept", k);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    s_tvalid  = 1'b0;
    rnd_ready = 0;
    m_tready  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== '0 || m_tuser !== '0 || m_tlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got tready=%b tvalid=%b tdata=%h tuser=%h tlast=%b want all 0",
               s_tready, m_tvalid, m_tdata, m_tuser, m_tlast);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    send_beat(0, 100, 0);
    send_beat(0, 200, 0);
    send_beat(0, 300, 0);
    send_beat(0, 400, 0);
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].data !== 24'd250 || obs_q[0].user !== 3'd0) begin
      failures++;
      $display("FAIL basic_mean got n=%0d data=%0d want n=1 data=250 user=0",
               obs_q.size(), (obs_q.size() > 0) ? $signed(obs_q[0].data) : 0);
    end
    checks++;
    if (obs_q.size() < 1 || obs_q[0].cyc != last_acc_cyc + 1) begin
      failures++;
      $display("FAIL basic_latency got cyc=%0d want cyc=%0d",
               (obs_q.size() > 0) ? obs_q[0].cyc : -1, last_acc_cyc + 1);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_negative();
    send_beat(3, -1, 0);
    send_beat(3, -1, 0);
    send_beat(3, -1, 0);
    send_beat(3, -2, 0);
    for (int i = 0; i < DECIM; i++) send_beat(4, -8388608, 0);
    for (int i = 0; i < DECIM; i++) send_beat(6, 8388607, 0);
    drain();
    checks++;
    if (obs_q.size() < 1 || obs_q[0].data !== 24'hFFFFFE || obs_q[0].user !== 3'd3) begin
      failures++;
      $display("FAIL neg_floor got data=%h want data=fffffe user=3",
               (obs_q.size() > 0) ? obs_q[0].data : 24'h0);
    end
    checks++;
    if (obs_q.size() < 2 || obs_q[1].data !== 24'h800000) begin
      failures++;
      $display("FAIL neg_fullscale got data=%h want data=800000",
               (obs_q.size() > 1) ? obs_q[1].data : 24'h0);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL neg_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].user !== exp_q[i].user || obs_q[i].last !== exp_q[i].last) begin
        failures++;
        $display("FAIL neg_beat%0d got data=%h user=%0d want data=%h user=%0d",
                 i, obs_q[i].data, obs_q[i].user, exp_q[i].data, exp_q[i].user);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_interleave();
    for (int b = 0; b < 4 * NS; b++) send_beat(b % NS, (b % NS) * 1000, 0);
    drain();
    checks++;
    if (obs_q.size() != NS) begin
      failures++;
      $display("FAIL ilv_count got=%0d want=%0d", obs_q.size(), NS);
    end
    for (int i = 0; i < NS && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== 24'(i * 1000) || obs_q[i].user !== 3'(i)) begin
        failures++;
        $display("FAIL ilv_beat%0d got data=%0d user=%0d want data=%0d user=%0d",
                 i, obs_q[i].data, obs_q[i].user, i * 1000, i);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    beat_t pend;
    for (int i = 0; i < DECIM - 1; i++) send_beat(2, rand_sample(), 0);
    m_tready = 1'b0;
    for (int i = 0; i < DECIM; i++) send_beat(1, rand_sample(), 0);
    pend = exp_q[exp_q.size() - 1];
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== pend.data || m_tuser !== pend.user) begin
        failures++;
        $display("FAIL stall_c%0d got tready=%b tvalid=%b data=%h user=%0d want tready=0 tvalid=1 data=%h user=%0d",
                 c, s_tready, m_tvalid, m_tdata, m_tuser, pend.data, pend.user);
      end
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    send_beat(2, rand_sample(), 0);
    drain();
    checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[1].cyc != obs_q[0].cyc + 1) begin
        failures++;
        $display("FAIL b2b_spacing got=%0d want=1", obs_q[1].cyc - obs_q[0].cyc);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_q[i].data !== exp_q[i].data || obs_q[i].user !== exp_q[i].user) begin
          failures++;
          $display("FAIL b2b_beat%0d got data=%h user=%0d want data=%h user=%0d",
                   i, obs_q[i].data, obs_q[i].user, exp_q[i].data, exp_q[i].user);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_tlast();
    for (int i = 0; i < 2 * DECIM; i++) send_beat(5, rand_sample(), i == 1);
    drain();
    checks++;
    if (obs_q.size() != 2 || obs_q[0].last !== 1'b1 || obs_q[1].last !== 1'b0) begin
      failures++;
      $display("FAIL tlast_sticky got n=%0d last0=%b last1=%b want n=2 last0=1 last1=0",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].last : 1'bx,
               (obs_q.size() > 1) ? obs_q[1].last : 1'bx);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    rnd_ready = 1;
    for (int b = 0; b < 300; b++)
      send_beat(int'($urandom_range(0, NS - 1)), rand_sample(), ($urandom_range(0, 7) == 0));
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].user !== exp_q[i].user || obs_q[i].last !== exp_q[i].last) begin
        failures++;
        $display("FAIL rand_beat%0d got data=%h user=%0d last=%b want data=%h user=%0d last=%b",
                 i, obs_q[i].data, obs_q[i].user, obs_q[i].last, exp_q[i].data, exp_q[i].user, exp_q[i].last);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int fill;
    send_beat(2, 50, 0);
    send_beat(2, 70, 0);
    m_tready = 1'b0;
    fill = DECIM - m_cnt[0];
    for (int i = 0; i < fill; i++) send_beat(0, rand_sample(), 1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== '0 || m_tuser !== '0 || m_tlast !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs got tready=%b tvalid=%b tdata=%h tuser=%h tlast=%b want all 0",
               s_tready, m_tvalid, m_tdata, m_tuser, m_tlast);
    end
    model_reset();
    obs_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < DECIM; i++) send_beat(2, 8, 0);
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].data !== 24'd8 || obs_q[0].user !== 3'd2) begin
      failures++;
      $display("FAIL midreset_discard got n=%0d data=%0d want n=1 data=8 user=2",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 24'h0);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_interleave();
    test_back_to_back();
    test_tlast();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
